// File: rtl/hs_consumer_fifo.sv
// hs_consumer_fifo: ready/ack handshake consumer feeding a DEPTH-entry FIFO
// with a valid/ready stream output, backpressure and a running receive count.
module hs_consumer_fifo #(
  parameter int N          = 8,
  parameter int DEPTH      = 4,
  parameter int FOUR_PHASE = 0
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     ready,
  output logic                     ack,
  input  logic [N-1:0]             pdata,
  output logic                     out_valid,
  input  logic                     out_rdy,
  output logic [N-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              rx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // ACKED doubles as the registered ack bit in both modes
  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic [15:0]    rx_q;
  logic           full;
  logic           push;
  logic           pop;

  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign pop       = out_valid && out_rdy;
  assign ack       = (state_q == ACKED);
  assign level     = level_q;
  assign rx_count  = rx_q;

  // handshake FSM: capture decision and next ack state
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready && !full) begin
          push    = 1'b1;
          state_d = ACKED;
        end
      end
      ACKED: begin
        if (FOUR_PHASE == 0 || !ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // occupancy update; a pop never frees room for a same-cycle push
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // control state, pointers, occupancy and receive counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        rx_q   <= rx_q + 16'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // storage array, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= pdata;
    end
  end

endmodule

// File: tb/tb_hs_consumer_fifo.sv
// tb_hs_consumer_fifo: random stimulus on pulse and four-phase instances,
// queue scoreboard against a transaction-level handshake model.
module tb_hs_consumer_fifo;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       ready = 1'b0;
  logic       out_rdy = 1'b0;
  logic [7:0] pdata = '0;

  logic       ack [2];
  logic       ov  [2];
  logic [7:0] od  [2];
  logic [2:0] lv  [2];
  logic [15:0] rc [2];

  hs_consumer_fifo #(.N(8), .DEPTH(D), .FOUR_PHASE(0)) u_p (
    .clk(clk), .rst_l(rst_l), .ready(ready), .ack(ack[0]),
    .pdata(pdata), .out_valid(ov[0]), .out_rdy(out_rdy),
    .out_data(od[0]), .level(lv[0]), .rx_count(rc[0])
  );

  hs_consumer_fifo #(.N(8), .DEPTH(D), .FOUR_PHASE(1)) u_f (
    .clk(clk), .rst_l(rst_l), .ready(ready), .ack(ack[1]),
    .pdata(pdata), .out_valid(ov[1]), .out_rdy(out_rdy),
    .out_data(od[1]), .level(lv[1]), .rx_count(rc[1])
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         lvl_m [2];
  bit         ack_m [2];
  int         cnt_m [2];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // one clock edge of the reference: inputs as sampled at that edge
  task automatic model_step(int i);
    bit push;
    bit pop;
    bit full;
    full = (lvl_m[i] == D);
    pop  = (lvl_m[i] != 0) && out_rdy;
    if (i == 0) begin
      push     = ready && !ack_m[i] && !full;
      ack_m[i] = push;
    end else if (!ack_m[i]) begin
      push     = ready && !full;
      ack_m[i] = push;
    end else begin
      push     = 1'b0;
      ack_m[i] = ready;
    end
    if (push) begin
      cnt_m[i] = (cnt_m[i] + 1) & 32'hFFFF;
      if (i == 0) q0.push_back(pdata);
      else q1.push_back(pdata);
    end
    lvl_m[i] = lvl_m[i] + int'(push) - int'(pop);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      lvl_m[i] = 0;
      ack_m[i] = 1'b0;
      cnt_m[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // monitor: compare registered outputs and drain the scoreboard on pops
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string  p;
      logic [7:0] e;
      bit     have;
      p = (i == 0) ? "pulse" : "4ph";
      chk({p, "_ack"},   int'(ack[i]), int'(ack_m[i]));
      chk({p, "_valid"}, int'(ov[i]),  int'(lvl_m[i] != 0));
      chk({p, "_level"}, int'(lv[i]),  lvl_m[i]);
      chk({p, "_rxcnt"}, int'(rc[i]),  cnt_m[i]);
      if (ov[i] && out_rdy) begin
        have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL %s_pop actual=%0h required=none t=%0t",
                   p, od[i], $time);
        end else begin
          if (i == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk({p, "_data"}, int'(od[i]), int'(e));
        end
      end
    end
  end

  task automatic run(int cyc, int rdy_pct, int ordy_pct, int fixed);
    repeat (cyc) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      ready   = ($urandom_range(99) < rdy_pct);
      out_rdy = ($urandom_range(99) < ordy_pct);
      pdata   = (fixed < 0) ? 8'($urandom) : 8'(fixed);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
    rst_l = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack",   int'(ack[i]), 0);
      chk("rst_valid", int'(ov[i]),  0);
      chk("rst_level", int'(lv[i]),  0);
      chk("rst_rxcnt", int'(rc[i]),  0);
    end
    #1;
    rst_l = 1'b1;
  endtask

  initial begin
    model_clear();
    #12;
    rst_l = 1'b1;
    run(20, 100, 100, 'hA5);
    run(20, 100, 0, -1);
    run(10, 100, 30, -1);
    run(400, 50, 50, -1);
    run(40, 85, 20, -1);
    run(40, 30, 90, -1);
    run(8, 100, 0, -1);
    mid_reset();
    run(200, 60, 60, -1);
    run(20, 0, 100, -1);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
